bp_cfg_link_decoder: RTL
========================

Name: bp_cfg_link_decoder

Overview:
- Sits directly downstream of the config link and consumes its command stream: one config command (addr, data, read/write) at a time.
- Decodes the command against the config memory map and holds the chip, FE, BE and ME config registers, driving them to the tile.
- Forwards accesses to the CCE ucode window to the CCE ucode port with a valid/yumi handshake.
- Returns read data on a response channel with a valid/ready handshake.

Parameters:
- vaddr_width_p, 39, start PC width; legal range 33..64.
- cfg_data_width_p, 32, config data width.
- cfg_addr_width_p, 16, config address width.
- mode_width_p, 2, width of the icache, dcache and cce mode fields.
- start_pc_reset_p, 'h0080000000, start_pc_o value after reset.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- cfg_v_i  in  1  command valid
- cfg_w_i  in  1  1=write, 0=read
- cfg_addr_i  in  cfg_addr_width_p  command address
- cfg_data_i  in  cfg_data_width_p  write data
- cfg_ready_o  out  1  command accepted when cfg_v_i & cfg_ready_o
- cfg_resp_v_o  out  1  read response valid
- cfg_resp_data_o  out  cfg_data_width_p  read data
- cfg_resp_ready_i  in  1  response consumer ready
- clk_osc_o  out  cfg_data_width_p  oscillator setting (addr 0x0000)
- core_reset_o  out  1  tile reset (0x0001, bit 0)
- freeze_o  out  1  tile freeze (0x0002, bit 0)
- icache_mode_o  out  mode_width_p  (0x0022)
- start_pc_o  out  vaddr_width_p  (0x0040 lo, 0x0041 hi)
- dcache_mode_o  out  mode_width_p  (0x0042)
- cce_mode_o  out  mode_width_p  (0x0060)
- ucode_v_o  out  1  ucode access valid
- ucode_w_o  out  1  ucode write
- ucode_addr_o  out  12  ucode word address
- ucode_data_o  out  cfg_data_width_p  ucode write data
- ucode_yumi_i  in  1  ucode port took the access
- ucode_resp_v_i  in  1  ucode read data valid (one cycle)
- ucode_resp_data_i  in  cfg_data_width_p  ucode read data

Behaviour:
- Reset values (reset_n_i low at a clock edge):
  - clk_osc_o=0, core_reset_o=1, freeze_o=1, all mode outputs=0, start_pc_o=start_pc_reset_p, staged lo=0.
  - ucode_v_o=0, cfg_resp_v_o=0, cfg_resp_data_o=0.
  - FSM=IDLE, cfg_ready_o=1 from the first cycle after reset.
- Reset mid-operation aborts any ucode access or pending response. Nothing is replayed.
- Decode:
  - addr[15:12]==4'h8 selects the ucode window; ucode_addr_o=addr[11:0].
  - Mapped register addresses are exactly those listed in Ports.
  - All other addresses are unmapped: writes are dropped, reads return 0.
- FSM states: IDLE, UCODE_REQ, UCODE_WAIT, RESP. cfg_ready_o=1 only in IDLE.
- IDLE, register write accepted: the target register updates at that edge, the output changes the next cycle, and the FSM stays in IDLE. Back-to-back writes are accepted every cycle.
- IDLE, register read accepted: cfg_resp_data_o is loaded with the register value (zero-extended), then go to RESP.
- IDLE, ucode access accepted: latch addr/data/w, then go to UCODE_REQ.
- UCODE_REQ: ucode_v_o=1 with stable outputs until ucode_yumi_i. On yumi, a write returns to IDLE and a read goes to UCODE_WAIT.
- UCODE_WAIT: on ucode_resp_v_i, capture ucode_resp_data_i into cfg_resp_data_o, then go to RESP.
- RESP: cfg_resp_v_o=1 until cfg_resp_ready_i, then return to IDLE. cfg_resp_data_o is held stable while valid.
- start_pc is updated atomically:
  - A write to 0x0040 stages data into the lo staging register only.
  - A write to 0x0041 commits start_pc_o={cfg_data_i[vaddr_width_p-33:0], staged_lo}. Upper data bits are ignored.
  - A read of 0x0040 returns start_pc_o[31:0] (committed, not staged).
  - A read of 0x0041 returns start_pc_o upper bits, zero-extended.
- For single-bit and mode registers, writes use the low bits and ignore the rest. Reads return the value zero-extended.
- Registers remain writable regardless of freeze_o and core_reset_o.

Test Plan:
- Reset, then idle 3 cycles -> freeze_o=1, core_reset_o=1, start_pc_o='h0080000000, cfg_ready_o=1.
- Write 0x0040=0x1234_5678 -> start_pc_o unchanged. Then write 0x0041=0x7F -> start_pc_o='h7F_1234_5678 one cycle after acceptance. Read 0x0041 -> resp 0x7F.
- Write 0x0002=0 then 0x0001=0 on back-to-back cycles -> freeze_o=0 and core_reset_o=0, each one cycle after its acceptance. cfg_ready_o stays high.
- Write 0x8005=0xDEAD_BEEF with ucode_yumi_i held low 4 cycles -> ucode_v_o high 5 cycles with addr 0x005 stable and cfg_ready_o=0. Returns to IDLE the cycle after yumi.
- Read 0x8010, yumi after 1 cycle, ucode_resp_v_i with 0xCAFE 3 cycles later, cfg_resp_ready_i low 2 cycles -> cfg_resp_v_o=1 with 0xCAFE stable for 3 cycles, then ready.
- Read 0x0100 -> resp 0. Assert reset_n_i low during UCODE_WAIT -> ucode_v_o=0, cfg_resp_v_o=0, and the response never issues.

Source files
------------

// File: rtl/bp_cfg_link_decoder_if.sv
// Config link command/response bundle between the link and the decoder.
interface bp_cfg_link_decoder_if #(
    parameter int cfg_data_width_p = 32,
    parameter int cfg_addr_width_p = 16
);
    logic                        cfg_v_i;
    logic                        cfg_w_i;
    logic [cfg_addr_width_p-1:0] cfg_addr_i;
    logic [cfg_data_width_p-1:0] cfg_data_i;
    logic                        cfg_ready_o;
    logic                        cfg_resp_v_o;
    logic [cfg_data_width_p-1:0] cfg_resp_data_o;
    logic                        cfg_resp_ready_i;

    // Link side: issues commands, consumes responses.
    modport master (
        output cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_resp_ready_i,
        input  cfg_ready_o, cfg_resp_v_o, cfg_resp_data_o
    );

    // Decoder side: accepts commands, produces responses.
    modport slave (
        input  cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_resp_ready_i,
        output cfg_ready_o, cfg_resp_v_o, cfg_resp_data_o
    );
endinterface

// File: rtl/bp_cfg_link_decoder.sv
// Config command decoder: holds tile config registers, forwards ucode window
// accesses to the CCE ucode port and returns read data on the response channel.
module bp_cfg_link_decoder #(
    parameter int                   vaddr_width_p    = 39,
    parameter int                   cfg_data_width_p = 32,
    parameter int                   cfg_addr_width_p = 16,
    parameter int                   mode_width_p     = 2,
    parameter logic [vaddr_width_p-1:0] start_pc_reset_p = 'h0080000000
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_cfg_link_decoder_if.slave          cfg,
    output logic [cfg_data_width_p-1:0]   clk_osc_o,
    output logic                          core_reset_o,
    output logic                          freeze_o,
    output logic [mode_width_p-1:0]       icache_mode_o,
    output logic [vaddr_width_p-1:0]      start_pc_o,
    output logic [mode_width_p-1:0]       dcache_mode_o,
    output logic [mode_width_p-1:0]       cce_mode_o,
    output logic                          ucode_v_o,
    output logic                          ucode_w_o,
    output logic [11:0]                   ucode_addr_o,
    output logic [cfg_data_width_p-1:0]   ucode_data_o,
    input  logic                          ucode_yumi_i,
    input  logic                          ucode_resp_v_i,
    input  logic [cfg_data_width_p-1:0]   ucode_resp_data_i
);
    localparam logic [cfg_addr_width_p-1:0] A_CLK_OSC  = 'h0000;
    localparam logic [cfg_addr_width_p-1:0] A_CORE_RST = 'h0001;
    localparam logic [cfg_addr_width_p-1:0] A_FREEZE   = 'h0002;
    localparam logic [cfg_addr_width_p-1:0] A_ICACHE   = 'h0022;
    localparam logic [cfg_addr_width_p-1:0] A_PC_LO    = 'h0040;
    localparam logic [cfg_addr_width_p-1:0] A_PC_HI    = 'h0041;
    localparam logic [cfg_addr_width_p-1:0] A_DCACHE   = 'h0042;
    localparam logic [cfg_addr_width_p-1:0] A_CCE      = 'h0060;

    typedef enum logic [1:0] {IDLE, UCODE_REQ, UCODE_WAIT, RESP} state_e;
    state_e state_q, state_d;

    logic [cfg_data_width_p-1:0] clk_osc_q;
    logic                        core_reset_q, freeze_q;
    logic [mode_width_p-1:0]     icache_mode_q, dcache_mode_q, cce_mode_q;
    logic [vaddr_width_p-1:0]    start_pc_q;
    logic [31:0]                 pc_lo_q;
    logic                        ucode_w_q;
    logic [11:0]                 ucode_addr_q;
    logic [cfg_data_width_p-1:0] ucode_data_q;
    logic [cfg_data_width_p-1:0] resp_data_q, resp_data_d;
    logic [cfg_data_width_p-1:0] rd_data;
    logic                        accept, is_ucode;

    assign accept   = cfg.cfg_v_i && (state_q == IDLE);
    assign is_ucode = (cfg.cfg_addr_i[15:12] == 4'h8);

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        unique case (cfg.cfg_addr_i)
            A_CLK_OSC:  rd_data = clk_osc_q;
            A_CORE_RST: rd_data = cfg_data_width_p'(core_reset_q);
            A_FREEZE:   rd_data = cfg_data_width_p'(freeze_q);
            A_ICACHE:   rd_data = cfg_data_width_p'(icache_mode_q);
            A_PC_LO:    rd_data = cfg_data_width_p'(start_pc_q[31:0]);
            A_PC_HI:    rd_data = cfg_data_width_p'(start_pc_q[vaddr_width_p-1:32]);
            A_DCACHE:   rd_data = cfg_data_width_p'(dcache_mode_q);
            A_CCE:      rd_data = cfg_data_width_p'(cce_mode_q);
            default:    rd_data = '0;
        endcase
    end

    // Next-state and response data selection.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_ucode) begin
                    state_d = UCODE_REQ;
                end else if (accept && !cfg.cfg_w_i) begin
                    state_d     = RESP;
                    resp_data_d = rd_data;
                end
            end
            UCODE_REQ: begin
                if (ucode_yumi_i) state_d = ucode_w_q ? IDLE : UCODE_WAIT;
            end
            UCODE_WAIT: begin
                if (ucode_resp_v_i) begin
                    state_d     = RESP;
                    resp_data_d = ucode_resp_data_i;
                end
            end
            RESP: begin
                if (cfg.cfg_resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, response data and latched ucode request.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            resp_data_q  <= '0;
            ucode_w_q    <= 1'b0;
            ucode_addr_q <= '0;
            ucode_data_q <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            if (accept && is_ucode) begin
                ucode_w_q    <= cfg.cfg_w_i;
                ucode_addr_q <= cfg.cfg_addr_i[11:0];
                ucode_data_q <= cfg.cfg_data_i;
            end
        end
    end

    // Config register writes; start_pc commits only on the hi-word write.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            clk_osc_q     <= '0;
            core_reset_q  <= 1'b1;
            freeze_q      <= 1'b1;
            icache_mode_q <= '0;
            dcache_mode_q <= '0;
            cce_mode_q    <= '0;
            start_pc_q    <= start_pc_reset_p;
            pc_lo_q       <= '0;
        end else if (accept && cfg.cfg_w_i && !is_ucode) begin
            unique case (cfg.cfg_addr_i)
                A_CLK_OSC:  clk_osc_q     <= cfg.cfg_data_i;
                A_CORE_RST: core_reset_q  <= cfg.cfg_data_i[0];
                A_FREEZE:   freeze_q      <= cfg.cfg_data_i[0];
                A_ICACHE:   icache_mode_q <= cfg.cfg_data_i[mode_width_p-1:0];
                A_PC_LO:    pc_lo_q       <= cfg.cfg_data_i[31:0];
                A_PC_HI:    start_pc_q    <= {cfg.cfg_data_i[vaddr_width_p-33:0], pc_lo_q};
                A_DCACHE:   dcache_mode_q <= cfg.cfg_data_i[mode_width_p-1:0];
                A_CCE:      cce_mode_q    <= cfg.cfg_data_i[mode_width_p-1:0];
                default:    ;
            endcase
        end
    end

    assign cfg.cfg_ready_o     = (state_q == IDLE);
    assign cfg.cfg_resp_v_o    = (state_q == RESP);
    assign cfg.cfg_resp_data_o = resp_data_q;
    assign ucode_v_o           = (state_q == UCODE_REQ);
    assign ucode_w_o           = ucode_w_q;
    assign ucode_addr_o        = ucode_addr_q;
    assign ucode_data_o        = ucode_data_q;
    assign clk_osc_o           = clk_osc_q;
    assign core_reset_o        = core_reset_q;
    assign freeze_o            = freeze_q;
    assign icache_mode_o       = icache_mode_q;
    assign dcache_mode_o       = dcache_mode_q;
    assign cce_mode_o          = cce_mode_q;
    assign start_pc_o          = start_pc_q;
endmodule
